mtx_unit_p: RTL

Parametrised successor matrix-vector engine for the NN datapath. Holds two N-element signed fixed-point vector registers (V0, V1) and an N x N ternary weight matrix (M0). Executes one command per valid/ready handshake. MVMUL runs as a multi-cycle operation that processes LANES rows per cycle. Results are returned on a valid/ready output channel, and registered status flags report each completed operation.

---
 rtl/mtx_unit_p.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mtx_unit_p.sv
// ---------------------------------------------------------------------------
// mtx_unit_p : matrix-vector engine for the NN datapath.
//
// Holds two N-element signed fixed-point vectors (V0, V1, format
// Q(DW-FRAC).FRAC) and an N x N ternary weight matrix (M0). One command is
// accepted per cmd_valid/cmd_ready handshake. MVMUL is multi-cycle and
// processes LANES rows per clock. ST_V0/ST_V1 present a register on the
// res_valid/res_ready channel. Status flags are registered.
//
// Optional feature: define MTX_UNIT_BIAS_EN to make MVMUL compute
// M0*V0 + V1, with the bias added inside the wide accumulator before the
// single final saturation. If it is undefined, MVMUL computes M0*V0 only.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   cmd_valid/ready command handshake (ready only while IDLE)
//   cmd_op          opcode (0..15)
//   cmd_row         target row for LD_MROW
//   cmd_vec         vector payload, element i at [i*DW +: DW]
//   cmd_mrow        ternary row payload, element c at [2c +: 2]
//   res_valid/ready result handshake; res_vec holds until accepted
//   res_vec         result vector, element i at [i*DW +: DW]
//   busy            MVMUL in progress
//   st_zero         last arithmetic result was all zero
//   st_of           last arithmetic op saturated at least one element
//   st_inv          last accepted opcode was invalid (15)
// ---------------------------------------------------------------------------
module mtx_unit_p #(
  parameter int N     = 8,
  parameter int DW    = 32,
  parameter int FRAC  = 16,
  parameter int LANES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [$clog2(N)-1:0] cmd_row,
  input  logic [N*DW-1:0]      cmd_vec,
  input  logic [2*N-1:0]       cmd_mrow,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N*DW-1:0]      res_vec,
  output logic                 busy,
  output logic                 st_zero,
  output logic                 st_of,
  output logic                 st_inv
);

  localparam int RW = $clog2(N);
  localparam int AW = DW + $clog2(N) + 1;             // MVMUL accumulator
  localparam int SW = (2 * DW > AW) ? 2 * DW : AW;    // common pre-saturation width

  localparam logic signed [DW-1:0] ONE   = {{(DW-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [SW-1:0] MAX_W = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_W = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [RW-1:0]        LAST_ROW = RW'(N - LANES);
  localparam logic [RW-1:0]        STEP     = RW'(LANES);

  if (N < 2 || (N % LANES) != 0) begin : g_param_check
    $error("mtx_unit_p: N must be >= 2 and a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, MUL, OUT} state_e;

  typedef enum logic [3:0] {
    OP_NOP, OP_LD_V0, OP_LD_V1, OP_LD_MROW, OP_ZERO_V0, OP_ZERO_V1, OP_ZERO_M0,
    OP_ST_V0, OP_ST_V1, OP_MVMUL, OP_VADD, OP_VSUB, OP_VRELU, OP_VHTANH,
    OP_VSQR, OP_INV
  } op_e;

  typedef struct packed {
    logic                 of;
    logic signed [DW-1:0] val;
  } sat_t;

  // Clamp a wide signed value into DW bits, flagging saturation.
  function automatic sat_t sat(input logic signed [SW-1:0] x);
    sat_t r;
    if (x > MAX_W) begin
      r.of  = 1'b1;
      r.val = {1'b0, {(DW-1){1'b1}}};
    end else if (x < MIN_W) begin
      r.of  = 1'b1;
      r.val = {1'b1, {(DW-1){1'b0}}};
    end else begin
      r.of  = 1'b0;
      r.val = x[DW-1:0];
    end
    return r;
  endfunction

  // Element-wise vector ops that write V0 (VADD..VSQR).
  function automatic sat_t vec_op(input op_e op,
                                  input logic signed [DW-1:0] a,
                                  input logic signed [DW-1:0] b);
    sat_t                   r;
    logic signed [2*DW-1:0] prod;
    r.of  = 1'b0;
    r.val = a;
    prod  = (2*DW)'(a) * (2*DW)'(a);
    case (op)
      OP_VADD:   r = sat(SW'(a) + SW'(b));
      OP_VSUB:   r = sat(SW'(a) - SW'(b));
      OP_VRELU:  r.val = a[DW-1] ? '0 : a;
      OP_VHTANH: begin
        if (a > ONE)       r.val = ONE;
        else if (a < -ONE) r.val = -ONE;
      end
      OP_VSQR:   r = sat(SW'(prod >>> FRAC));
      default:   ;
    endcase
    return r;
  endfunction

  state_e               state, state_nxt;
  op_e                  op;
  logic                 accept;
  logic signed [DW-1:0] v0      [N];
  logic signed [DW-1:0] v1      [N];
  logic [2*N-1:0]       m0      [N];
  logic signed [DW-1:0] buf_q   [N];
  logic signed [DW-1:0] buf_nxt [N];
  logic [RW-1:0]        row_cnt;
  logic                 of_acc;
  logic                 lane_of;
  logic                 mul_zero;
  sat_t                 vop     [N];
  logic                 vop_of;
  logic                 vop_zero;

  assign op     = op_e'(cmd_op);
  assign accept = cmd_valid && cmd_ready;

  // ---------------- FSM: state register ----------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from the values sampled at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: each combinational block assigns its outputs a default first so no
  // path leaves them unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (op == OP_MVMUL)                         state_nxt = MUL;
        else if (op == OP_ST_V0 || op == OP_ST_V1)  state_nxt = OUT;
      end
      MUL:     if (row_cnt == LAST_ROW) state_nxt = IDLE;
      OUT:     if (res_ready)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state == MUL);
    res_valid = (state == OUT);
  end

  // ---------------- vector-op datapath ----------------
  always_comb begin
    vop_of   = 1'b0;
    vop_zero = 1'b1;
    for (int i = 0; i < N; i++) begin
      vop[i]   = vec_op(op, v0[i], v1[i]);
      vop_of   = vop_of | vop[i].of;
      vop_zero = vop_zero & (vop[i].val == '0);
    end
  end

  // ---------------- MVMUL lanes ----------------
  // Rows row_cnt .. row_cnt+LANES-1 are produced this cycle and merged into
  // the buffer image; V0 is only read here, so every row sees the V0 value
  // held at command accept.
  always_comb begin : mvmul_lanes
    logic signed [AW-1:0] acc;
    logic [RW-1:0]        ridx;
    sat_t                 s;
    acc      = '0;
    ridx     = '0;
    s        = '0;
    lane_of  = 1'b0;
    buf_nxt  = buf_q;
    for (int l = 0; l < LANES; l++) begin
      ridx = row_cnt + RW'(l);
      acc  = '0;
      for (int c = 0; c < N; c++) begin
        case (m0[ridx][2*c +: 2])
          2'b01:   acc = acc + AW'(v0[c]);
          2'b11:   acc = acc - AW'(v0[c]);
          default: ;                         // 2'b00 and reserved 2'b10 are zero
        endcase
      end
`ifdef MTX_UNIT_BIAS_EN
      acc = acc + AW'(v1[ridx]);
`endif
      s             = sat(SW'(acc));
      buf_nxt[ridx] = s.val;
      lane_of       = lane_of | s.of;
    end
    mul_zero = 1'b1;
    for (int i = 0; i < N; i++) mul_zero = mul_zero & (buf_nxt[i] == '0);
  end

  // ---------------- registers ----------------
  // NOTE: V0/V1/M0 and the buffer are register arrays, not RAM, and the
  // unit must come out of reset with them cleared, so they are reset here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        v0[i]    <= '0;
        v1[i]    <= '0;
        m0[i]    <= '0;
        buf_q[i] <= '0;
      end
      row_cnt <= '0;
      of_acc  <= 1'b0;
      res_vec <= '0;
      st_zero <= 1'b0;
      st_of   <= 1'b0;
      st_inv  <= 1'b0;
    end else if (accept) begin
      st_inv <= (op == OP_INV);
      case (op)
        OP_LD_V0:   for (int i = 0; i < N; i++) v0[i] <= cmd_vec[i*DW +: DW];
        OP_LD_V1:   for (int i = 0; i < N; i++) v1[i] <= cmd_vec[i*DW +: DW];
        OP_LD_MROW: m0[cmd_row] <= cmd_mrow;
        OP_ZERO_V0: for (int i = 0; i < N; i++) v0[i] <= '0;
        OP_ZERO_V1: for (int i = 0; i < N; i++) v1[i] <= '0;
        OP_ZERO_M0: for (int i = 0; i < N; i++) m0[i] <= '0;
        OP_ST_V0:   for (int i = 0; i < N; i++) res_vec[i*DW +: DW] <= v0[i];
        OP_ST_V1:   for (int i = 0; i < N; i++) res_vec[i*DW +: DW] <= v1[i];
        OP_MVMUL: begin
          row_cnt <= '0;
          of_acc  <= 1'b0;
        end
        OP_VADD, OP_VSUB, OP_VRELU, OP_VHTANH, OP_VSQR: begin
          for (int i = 0; i < N; i++) v0[i] <= vop[i].val;
          st_zero <= vop_zero;
          st_of   <= vop_of;
        end
        default: ;
      endcase
    end else if (state == MUL) begin
      buf_q <= buf_nxt;
      if (row_cnt == LAST_ROW) begin
        v0      <= buf_nxt;
        st_zero <= mul_zero;
        st_of   <= of_acc | lane_of;
        row_cnt <= '0;
      end else begin
        row_cnt <= row_cnt + STEP;
        of_acc  <= of_acc | lane_of;
      end
    end
  end

endmodule
